simpleuart_rx: RTL and testbench
================================

# simpleuart_rx

Standalone 8N1 UART receiver, the receive-side counterpart of `simpleuart`, using the same divider semantics and register-port style so the two can share one bus decode in the SoC. It synchronises `ser_rx`, detects and validates start bits, samples data at mid-bit, checks the stop bit, and queues received bytes in a small FIFO. The CPU reads bytes through `reg_dat`; sticky error flags are exposed through `reg_err`.

## Interface
- `DEFAULT_DIV`, 1: divider value loaded at reset. Bit period is divider + 2 clocks.
- `DEPTH`, 4: FIFO depth in bytes. Must be a power of two, at least 2.
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `ser_rx` in 1: serial input, idle high, asynchronous to `clk`.
- `reg_div_we` in 4: byte write enables for the divider.
- `reg_div_di` in 32: divider write data.
- `reg_div_do` out 32: current divider value.
- `reg_dat_re` in 1: pop one byte.
- `reg_dat_do` out 32: `{24'h0, head byte}` when the FIFO is non-empty, otherwise `32'hFFFF_FFFF`.
- `reg_err_clr` in 1: clear both error flags.
- `reg_err_do` out 2: sticky flags, bit0 = frame error, bit1 = overrun.
- `rx_valid` out 1: FIFO is non-empty (interrupt source).

## Operation
- Input synchronisation: `ser_rx` passes through a 2-flop synchroniser to give `rx_s`; the synchroniser flops reset to 1. Everything below uses `rx_s`.
- Timing constants:
  - P = div + 2, computed in 32-bit unsigned arithmetic with wrap ignored.
  - H = P >> 1.
  - The down-counter is 32 bits wide.
- State machine: WAIT_IDLE, IDLE, START, DATA, STOP.
  - WAIT_IDLE → IDLE on the first cycle with `rx_s` = 1.
  - IDLE: when `rx_s` = 0, load count = H and go to START.
  - START: when count expires, sample `rx_s`. If it is 1 (glitch), go to IDLE. If it is 0, load count = P, set bit index = 0 and go to DATA.
  - DATA: on each expiry, shift `rx_s` into the MSB of the shift register (LSB-first line order) and reload count = P. After bit 7, go to STOP.
  - STOP: on expiry, sample `rx_s`.
    - If 1: push the byte and go to IDLE.
    - If 0: set the frame-error flag, discard the byte and go to WAIT_IDLE (break handling).
- Divider write: any nonzero `reg_div_we` updates the enabled bytes at the clock edge. The FSM is then forced to WAIT_IDLE, aborting any frame in progress; no byte is pushed and no flag is set.
- FIFO behaviour:
  - A push when full drops the new byte and sets the overrun flag.
  - A pop when empty is ignored.
  - Push and pop in the same cycle while full: the pop and the push both succeed and overrun is not set.
  - Push and pop in the same cycle while empty: the pushed byte is stored and the pop is ignored.
- Error flags:
  - `reg_err_clr` clears both flags.
  - If a set event and a clear occur in the same cycle, the set wins.
- Reset values:
  - `reg_div_do` = `DEFAULT_DIV`.
  - `reg_dat_do` = `32'hFFFF_FFFF`.
  - `reg_err_do` = 0.
  - `rx_valid` = 0.
  - FSM in WAIT_IDLE, FIFO empty.

## Timing
- A falling edge on `ser_rx` reaches `rx_s` 2 cycles later.
- Sample points, measured from the IDLE cycle that sees `rx_s` = 0:
  - Start check at +H.
  - Data bit n at +H + (n+1)·P.
  - Stop bit at +H + 9·P.
- The push is registered in the stop-sample cycle. `rx_valid` and `reg_dat_do` update on the next cycle.
- `reg_dat_re` pops at the clock edge; `reg_dat_do` shows the next head (or all-ones) in the following cycle. Holding `reg_dat_re` high pops one byte per cycle.
- `reg_div_do` reflects a write one cycle after the write edge.
- No wait states: all register reads are purely combinational from registered state.

## Structure
- The shared `simpleuart_pkg` holds:
  - the FSM state enum;
  - `UART_DATA_BITS` = 8;
  - `UART_DIV_OFFSET` = 2;
  - `UART_EMPTY` = `32'hFFFF_FFFF`.
- Sub-module `simpleuart_rx_fifo`: a DEPTH × 8 synchronous FIFO with `push`, `pop`, `din`, `dout`, `full` and `empty`, using log2(DEPTH)+1-bit wrap pointers. Full/empty are decided by the extra MSB.
- The top level contains the synchroniser, the FSM with its counter, the divider register and the flags.

## Test plan
- Reset, then idle: `reg_div_do` = 1, `reg_dat_do` = `FFFF_FFFF`, `rx_valid` = 0, `reg_err_do` = 0.
- Set div = 48 (P = 50 clocks = 500 ns) and drive frame 0-11001000-1 (byte 0x13), 500 ns per bit.
  - Expect `rx_valid` = 1 and `reg_dat_do` = `0000_0013` about 477 clocks after the start edge.
  - One cycle of `reg_dat_re` → `FFFF_FFFF` and `rx_valid` = 0.
- Start glitch: with div = 48, drive `ser_rx` low for 10 clocks → no byte and no flags.
- Frame error: send 0x55 with the stop bit low, then release the line high → `reg_err_do` = `01` and FIFO empty. Send 0xA5 → received correctly. Pulse `reg_err_clr` → `reg_err_do` = 0.
- Overrun: send 0x01…0x05 without reading, with DEPTH = 4.
  - Expect `reg_err_do[1]` = 1.
  - Reads return 0x01 to 0x04, then `FFFF_FFFF`.
  - Repeat with a pop in the same cycle as the 5th push → no overrun.
- Divider write mid-frame at data bit 3 → no byte pushed. A following full frame at the new rate (div = 10) is received correctly.

Source files
------------

// File: rtl/simpleuart_pkg.sv
// Shared definitions for the simpleuart transmit/receive pair.
// Holds the receiver FSM encoding and the divider/data-width constants.
package simpleuart_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_IDLE,
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_e;

   localparam int          UART_DATA_BITS  = 8;
   localparam logic [31:0] UART_DIV_OFFSET = 32'd2;
   localparam logic [31:0] UART_EMPTY      = 32'hFFFF_FFFF;

endpackage

// File: rtl/simpleuart_rx_fifo.sv
// Small byte FIFO for the UART receiver. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module simpleuart_rx_fifo
   import simpleuart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      push,
   input  logic                      pop,
   input  logic [UART_DATA_BITS-1:0] din,
   output logic [UART_DATA_BITS-1:0] dout,
   output logic                      full,
   output logic                      empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]                                wr_ptr_q, wr_ptr_d;
   logic [AW:0]                                rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0][UART_DATA_BITS-1:0]       mem_q, mem_d;
   logic                                       do_pop, do_push;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/simpleuart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, divider register,
// sticky error flags and a byte FIFO read through the register port.
module simpleuart_rx
   import simpleuart_pkg::*;
#(
   parameter logic [31:0] DEFAULT_DIV = 32'd1,
   parameter int          DEPTH       = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ser_rx,
   input  logic [3:0]  reg_div_we,
   input  logic [31:0] reg_div_di,
   output logic [31:0] reg_div_do,
   input  logic        reg_dat_re,
   output logic [31:0] reg_dat_do,
   input  logic        reg_err_clr,
   output logic [1:0]  reg_err_do,
   output logic        rx_valid
);

   rx_state_e                 state_q, state_d;
   logic                      sync_q, rx_s_q;
   logic [31:0]               div_q, div_d;
   logic [31:0]               cnt_q, cnt_d;
   logic [2:0]                bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
   logic [1:0]                err_q, err_d;

   logic [31:0]               period, half;
   logic                      expired, div_wr, push, frame_err, overrun;
   logic                      fifo_full, fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_dout;

   assign period  = div_q + UART_DIV_OFFSET;
   assign half    = period >> 1;
   assign expired = (cnt_q <= 32'd1);
   assign div_wr  = |reg_div_we;

   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q != 32'd0) ? cnt_q - 32'd1 : cnt_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      push      = 1'b0;
      frame_err = 1'b0;
      case (state_q)
         ST_WAIT_IDLE: if (rx_s_q) state_d = ST_IDLE;
         ST_IDLE: if (!rx_s_q) begin
            cnt_d   = half;
            state_d = ST_START;
         end
         ST_START: if (expired) begin
            if (rx_s_q) state_d = ST_IDLE;
            else begin
               cnt_d   = period;
               bit_d   = 3'd0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: if (expired) begin
            shreg_d = {rx_s_q, shreg_q[UART_DATA_BITS-1:1]};
            cnt_d   = period;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = ST_STOP;
         end
         ST_STOP: if (expired) begin
            // A low stop bit is treated as a break: wait for the line to idle.
            if (rx_s_q) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               frame_err = 1'b1;
               state_d   = ST_WAIT_IDLE;
            end
         end
         default: state_d = ST_WAIT_IDLE;
      endcase
      // Changing the rate mid-frame makes the frame meaningless; drop it silently.
      if (div_wr) begin
         state_d   = ST_WAIT_IDLE;
         push      = 1'b0;
         frame_err = 1'b0;
      end
   end

   always_comb begin
      div_d = div_q;
      for (int i = 0; i < 4; i++)
         if (reg_div_we[i]) div_d[8*i +: 8] = reg_div_di[8*i +: 8];
   end

   assign overrun = push && fifo_full && !reg_dat_re;

   always_comb begin
      err_d = reg_err_clr ? 2'b00 : err_q;
      err_d = err_d | {overrun, frame_err};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q  <= 1'b1;
         rx_s_q  <= 1'b1;
         state_q <= ST_WAIT_IDLE;
         div_q   <= DEFAULT_DIV;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         err_q   <= '0;
      end else begin
         sync_q  <= ser_rx;
         rx_s_q  <= sync_q;
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         err_q   <= err_d;
      end
   end

   simpleuart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .pop    (reg_dat_re),
      .din    (shreg_q),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign reg_div_do = div_q;
   assign reg_dat_do = fifo_empty ? UART_EMPTY : {24'h0, fifo_dout};
   assign reg_err_do = err_q;
   assign rx_valid   = !fifo_empty;

endmodule

// File: tb/tb_simpleuart_rx.sv
// Bench for simpleuart_rx: a cycle-indexed line-history model predicts FIFO
// contents and flags from the sample-point formulas; directed frames pin it.
module tb_simpleuart_rx;
   localparam int DEPTH = 4;
   localparam int N     = 65536;

   logic        clk = 1'b0, resetn = 1'b0, ser_rx = 1'b1;
   logic        reg_dat_re = 1'b0, reg_err_clr = 1'b0;
   logic [3:0]  reg_div_we = 4'h0;
   logic [31:0] reg_div_di = 32'h0;
   logic [31:0] reg_div_do, reg_dat_do;
   logic [1:0]  reg_err_do;
   logic        rx_valid;

   int errors = 0, checks = 0;

   simpleuart_rx #(.DEFAULT_DIV(32'd1), .DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .ser_rx(ser_rx),
      .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
      .reg_dat_re(reg_dat_re), .reg_dat_do(reg_dat_do),
      .reg_err_clr(reg_err_clr), .reg_err_do(reg_err_do), .rx_valid(rx_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // hist[k] is the synchronised line value during cycle k (2-cycle delay).
   bit          hist[N];
   bit          m_s1;
   int          k, c, mode;            // mode 0 wait-idle, 1 idle, 2 in frame
   longint      m_p, m_h;
   logic [31:0] m_div;
   logic [1:0]  m_err;
   byte unsigned q[$];

   initial begin
      bit          push, fe, ov, npop;
      byte unsigned b;
      mode = 0; m_div = 32'd1; m_err = 2'b00; m_s1 = 1'b1; k = 0; hist[0] = 1'b1;
      c = 0; m_p = 0; m_h = 0;
      @(posedge resetn);
      forever begin
         @(posedge clk);
         push = 0; fe = 0; ov = 0; b = 0;
         if (reg_div_we != 4'h0) begin
            for (int i = 0; i < 4; i++)
               if (reg_div_we[i]) m_div[8*i +: 8] = reg_div_di[8*i +: 8];
            mode = 0;
         end else if (mode == 0) begin
            if (hist[k % N]) mode = 1;
         end else if (mode == 1) begin
            if (!hist[k % N]) begin
               mode = 2; c = k;
               m_p = longint'(m_div) + 2; m_h = m_p / 2;
            end
         end else begin
            if (k == c + m_h && hist[k % N]) mode = 1;
            else if (k == c + m_h + 9 * m_p) begin
               for (int n = 0; n < 8; n++)
                  b[n] = hist[int'((c + m_h + (n + 1) * m_p) % N)];
               if (hist[k % N]) begin push = 1; mode = 1; end
               else begin fe = 1; mode = 0; end
            end
         end
         npop = reg_dat_re && (q.size() > 0);
         if (npop) void'(q.pop_front());
         if (push) begin
            if (q.size() < DEPTH) q.push_back(b);
            else ov = 1;
         end
         if (reg_err_clr) m_err = 2'b00;
         m_err = m_err | {ov, fe};
         hist[(k + 1) % N] = m_s1;
         m_s1 = ser_rx;
         k++;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      @(posedge resetn);
      forever begin
         @(negedge clk);
         chk("model valid", {31'h0, rx_valid}, {31'h0, q.size() > 0});
         chk("model dat", reg_dat_do, (q.size() > 0) ? {24'h0, q[0]} : 32'hFFFF_FFFF);
         chk("model err", {30'h0, reg_err_do}, {30'h0, m_err});
         chk("model div", reg_div_do, m_div);
      end
   end

   // ---------------- stimulus ----------------
   int bit_len = 50;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      ser_rx = 1'b0; tick(bit_len);
      for (int i = 0; i < 8; i++) begin ser_rx = b[i]; tick(bit_len); end
      ser_rx = stop; tick(bit_len);
      ser_rx = 1'b1; tick(bit_len);
   endtask

   task automatic write_div(input logic [31:0] v);
      reg_div_we = 4'hF; reg_div_di = v; tick(1);
      reg_div_we = 4'h0;
   endtask

   task automatic pop1();
      reg_dat_re = 1'b1; tick(1); reg_dat_re = 1'b0;
   endtask

   task automatic rd(input string name, input logic [31:0] exp);
      chk(name, reg_dat_do, exp);
      pop1();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset div", reg_div_do, 32'd1);
      chk("reset dat", reg_dat_do, 32'hFFFF_FFFF);
      chk("reset valid", {31'h0, rx_valid}, 32'd0);
      chk("reset err", {30'h0, reg_err_do}, 32'd0);
      resetn = 1'b1;
      tick(5);
      write_div(32'd48);
      chk("div 48", reg_div_do, 32'd48);
      tick(60);

      // 0x13 with exact arrival time: 2 sync + 25 + 9*50 cycles after start edge
      fork
         send_byte(8'h13, 1'b1);
         begin
            tick(477);
            chk("0x13 not yet", {31'h0, rx_valid}, 32'd0);
            tick(1);
            chk("0x13 valid", {31'h0, rx_valid}, 32'd1);
            chk("0x13 data", reg_dat_do, 32'h13);
         end
      join
      pop1();
      chk("after pop dat", reg_dat_do, 32'hFFFF_FFFF);
      chk("after pop valid", {31'h0, rx_valid}, 32'd0);

      // start glitch
      ser_rx = 1'b0; tick(10); ser_rx = 1'b1; tick(100);
      chk("glitch valid", {31'h0, rx_valid}, 32'd0);
      chk("glitch err", {30'h0, reg_err_do}, 32'd0);

      // frame error, recovery, clear
      send_byte(8'h55, 1'b0);
      chk("ferr flag", {30'h0, reg_err_do}, 32'd1);
      chk("ferr empty", {31'h0, rx_valid}, 32'd0);
      send_byte(8'hA5, 1'b1);
      rd("0xA5", 32'hA5);
      reg_err_clr = 1'b1; tick(1); reg_err_clr = 1'b0;
      chk("err clr", {30'h0, reg_err_do}, 32'd0);

      // overrun
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
      chk("overrun flag", {30'h0, reg_err_do}, 32'd2);
      for (int i = 1; i <= 4; i++) rd("ovr read", 32'(i));
      chk("ovr drained", reg_dat_do, 32'hFFFF_FFFF);
      reg_err_clr = 1'b1; tick(1); reg_err_clr = 1'b0;

      // push and pop together while full
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
      fork
         send_byte(8'h05, 1'b1);
         begin
            tick(477);
            reg_dat_re = 1'b1; tick(1); reg_dat_re = 1'b0;
         end
      join
      chk("no overrun", {30'h0, reg_err_do}, 32'd0);
      for (int i = 2; i <= 5; i++) rd("full pop read", 32'(i));
      chk("full pop drained", reg_dat_re ? 32'h0 : reg_dat_do, 32'hFFFF_FFFF);

      // divider write during data bit 3 aborts the frame
      fork
         send_byte(8'hF0, 1'b1);
         begin tick(225); write_div(32'd10); end
      join
      chk("abort valid", {31'h0, rx_valid}, 32'd0);
      chk("abort err", {30'h0, reg_err_do}, 32'd0);
      chk("div 10", reg_div_do, 32'd10);
      bit_len = 12;
      send_byte(8'h96, 1'b1);
      rd("0x96 at div 10", 32'h96);
      tick(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
